// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - serial PAT_LEN-bit pattern detector with one-cycle match strobe
// Optional saturating match counter enabled by defining SEQ_PATDET_COUNT_EN.
module seq_pattern_detector #(
  parameter int unsigned        PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b100,
  parameter int unsigned        OVERLAP = 0,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             In1,
  input  logic             in_valid,
  input  logic             clr,
  output logic             Out1
`ifdef SEQ_PATDET_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  generate
    if (PAT_LEN < 2 || PAT_LEN > 32 || CNT_W < 1) begin : g_bad_param
      $error("seq_pattern_detector: PAT_LEN must be 2..32 and CNT_W >= 1");
    end
  endgenerate

  // fill only needs to reach PAT_LEN-1, so clog2(PAT_LEN) bits suffice
  localparam int unsigned FW = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam logic [FW-1:0] FILL_ARMED = FW'(PAT_LEN - 1);

  logic [PAT_LEN-2:0] hist;
  logic [FW-1:0]      fill;
  logic [PAT_LEN-1:0] cand;
  logic               armed;
  logic               hit;

  assign cand  = {hist, In1};
  assign armed = (fill == FILL_ARMED);
  assign hit   = in_valid && armed && (cand == PATTERN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hist <= '0;
      fill <= '0;
      Out1 <= 1'b0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
      Out1 <= 1'b0;
    end else if (in_valid) begin
      Out1 <= hit;
      if (hit && OVERLAP == 0) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= cand[PAT_LEN-2:0];
        if (!armed) begin
          fill <= fill + FW'(1);
        end
      end
    end else begin
      Out1 <= 1'b0;
    end
  end

`ifdef SEQ_PATDET_COUNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      match_cnt <= '0;
    end else if (clr) begin
      match_cnt <= '0;
    end else if (hit && match_cnt != {CNT_W{1'b1}}) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - directed self-checking bench for seq_pattern_detector
// Several parameterisations share one input stream; each test checks the instances it targets.
module tb_seq_pattern_detector;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic In1 = 1'b0;
  logic in_valid = 1'b0;
  logic clr = 1'b0;

  logic o100, o101n, o101o, o000n, o000o, op2;
`ifdef SEQ_PATDET_COUNT_EN
  logic [1:0] c100, c101n, c101o, c000n, c000o, cp2;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  seq_pattern_detector #(.PAT_LEN(3), .PATTERN(3'b100), .OVERLAP(0), .CNT_W(2)) u100 (
    .CLK(CLK), .RST(RST), .In1(In1), .in_valid(in_valid), .clr(clr), .Out1(o100)
`ifdef SEQ_PATDET_COUNT_EN
    , .match_cnt(c100)
`endif
  );
  seq_pattern_detector #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(0), .CNT_W(2)) u101n (
    .CLK(CLK), .RST(RST), .In1(In1), .in_valid(in_valid), .clr(clr), .Out1(o101n)
`ifdef SEQ_PATDET_COUNT_EN
    , .match_cnt(c101n)
`endif
  );
  seq_pattern_detector #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(2)) u101o (
    .CLK(CLK), .RST(RST), .In1(In1), .in_valid(in_valid), .clr(clr), .Out1(o101o)
`ifdef SEQ_PATDET_COUNT_EN
    , .match_cnt(c101o)
`endif
  );
  seq_pattern_detector #(.PAT_LEN(3), .PATTERN(3'b000), .OVERLAP(0), .CNT_W(2)) u000n (
    .CLK(CLK), .RST(RST), .In1(In1), .in_valid(in_valid), .clr(clr), .Out1(o000n)
`ifdef SEQ_PATDET_COUNT_EN
    , .match_cnt(c000n)
`endif
  );
  seq_pattern_detector #(.PAT_LEN(3), .PATTERN(3'b000), .OVERLAP(1), .CNT_W(2)) u000o (
    .CLK(CLK), .RST(RST), .In1(In1), .in_valid(in_valid), .clr(clr), .Out1(o000o)
`ifdef SEQ_PATDET_COUNT_EN
    , .match_cnt(c000o)
`endif
  );
  seq_pattern_detector #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)) up2 (
    .CLK(CLK), .RST(RST), .In1(In1), .in_valid(in_valid), .clr(clr), .Out1(op2)
`ifdef SEQ_PATDET_COUNT_EN
    , .match_cnt(cp2)
`endif
  );

  task automatic drive(input logic b, input logic v, input logic c);
    In1 = b;
    in_valid = v;
    clr = c;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    In1 = 1'b0;
    in_valid = 1'b0;
    clr = 1'b0;
    RST = 1'b1;
    #2;
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    outs = {o100, o101n, o101o, o000n, o000o, op2};
    checks++;
    if (outs !== 6'b0) begin
      $display("FAIL reset_out1 got=%b exp=000000", outs);
      failures++;
    end
`ifdef SEQ_PATDET_COUNT_EN
    checks++;
    if ({c100, c101n, c101o, c000n, c000o, cp2} !== 12'b0) begin
      $display("FAIL reset_cnt got=%h exp=000", {c100, c101n, c101o, c000n, c000o, cp2});
      failures++;
    end
`endif
  endtask

  task automatic test_basic_100();
    logic b[7] = '{1, 0, 0, 1, 1, 0, 0};
    logic e[7] = '{0, 0, 1, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(b[i], 1'b1, 1'b0);
      checks++;
      if (o100 !== e[i]) begin
        $display("FAIL basic_100 step=%0d got=%b exp=%b", i, o100, e[i]);
        failures++;
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (o100 !== 1'b0) begin
      $display("FAIL basic_100_pulse_width got=%b exp=0", o100);
      failures++;
    end
  endtask

  task automatic test_overlap_101();
    logic b[5]  = '{1, 0, 1, 0, 1};
    logic en[5] = '{0, 0, 1, 0, 0};
    logic eo[5] = '{0, 0, 1, 0, 1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(b[i], 1'b1, 1'b0);
      checks++;
      if ({o101n, o101o} !== {en[i], eo[i]}) begin
        $display("FAIL overlap_101 step=%0d got=%b%b exp=%b%b", i, o101n, o101o, en[i], eo[i]);
        failures++;
      end
    end
  endtask

  task automatic test_gaps();
    logic b[7] = '{1, 0, 0, 0, 0, 0, 0};
    logic v[7] = '{1, 0, 0, 1, 0, 1, 0};
    logic e[7] = '{0, 0, 0, 0, 0, 1, 0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(b[i], v[i], 1'b0);
      checks++;
      if (o100 !== e[i]) begin
        $display("FAIL gaps step=%0d got=%b exp=%b", i, o100, e[i]);
        failures++;
      end
    end
  endtask

  task automatic test_zero_pattern();
    logic en[4] = '{0, 0, 1, 0};
    logic eo[4] = '{0, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      checks++;
      if ({o000n, o000o, o100} !== {en[i], eo[i], 1'b0}) begin
        $display("FAIL zero_pattern step=%0d got=%b%b%b exp=%b%b0", i, o000n, o000o, o100, en[i], eo[i]);
        failures++;
      end
    end
  endtask

  task automatic test_clr_and_async_reset();
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    checks++;
    if (o100 !== 1'b0) begin
      $display("FAIL clr_beats_hit got=%b exp=0", o100);
      failures++;
    end
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (o100 !== 1'b0) begin
      $display("FAIL clr_flushed_history got=%b exp=0", o100);
      failures++;
    end
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (o100 !== 1'b1) begin
      $display("FAIL pre_async_hit got=%b exp=1", o100);
      failures++;
    end
    in_valid = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (o100 !== 1'b0) begin
      $display("FAIL async_reset_out1 got=%b exp=0", o100);
      failures++;
    end
`ifdef SEQ_PATDET_COUNT_EN
    checks++;
    if (c100 !== 2'd0) begin
      $display("FAIL async_reset_cnt got=%0d exp=0", c100);
      failures++;
    end
`endif
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    #2;
    RST = 1'b1;
    #2;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (o100 !== 1'b0) begin
      $display("FAIL reset_discards_partial got=%b exp=0", o100);
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    logic b[5] = '{1, 1, 1, 0, 1};
    logic e[5] = '{0, 1, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(b[i], 1'b1, 1'b0);
      checks++;
      if (op2 !== e[i]) begin
        $display("FAIL back_to_back_len2 step=%0d got=%b exp=%b", i, op2, e[i]);
        failures++;
      end
    end
  endtask

`ifdef SEQ_PATDET_COUNT_EN
  task automatic test_counter();
    logic [1:0] exp_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      checks++;
      if (c100 !== exp_cnt[k] || o100 !== 1'b1) begin
        $display("FAIL counter_sat rep=%0d cnt=%0d exp=%0d out1=%b", k, c100, exp_cnt[k], o100);
        failures++;
      end
    end
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (c100 !== 2'd0) begin
      $display("FAIL counter_clr got=%0d exp=0", c100);
      failures++;
    end
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    checks++;
    if (c100 !== 2'd0) begin
      $display("FAIL counter_clr_beats_hit got=%0d exp=0", c100);
      failures++;
    end
  endtask
`endif

  initial begin
    @(posedge CLK);
    #1;
    RST = 1'b0;
    test_reset();
    test_basic_100();
    test_overlap_101();
    test_gaps();
    test_zero_pattern();
    test_clr_and_async_reset();
    test_back_to_back();
`ifdef SEQ_PATDET_COUNT_EN
    test_counter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
